hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It keeps its own shadow of the destination-register state of in-flight instructions in EX, MEM and WB. From that state it drives the `sel` inputs of the two EX-stage operand `mux3` forwarding muxes, inserts load-use bubbles, flushes on taken branches, and freezes everything on a memory stall. It sits beside the datapath and is fed decode-stage fields plus EX branch resolution.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/fwd_sel_gen.sv | 33 +++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: forwarding-mux select encoding and stage records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

   localparam int RF_ADDR_W = 5;

   // Encoding follows the mux3 input order: register file, WB result, MEM result.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Destination-side shadow of one in-flight instruction.
   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] rd;
      logic                 reg_write;
      logic                 is_load;
   } stage_rec_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the decode/EX datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: mem_stall in, stall_*/flush_* out; no valid/ready pairs.
// master: datapath side (drives decode fields, branch, mem_stall).
// slave : hazard_ctrl (drives forward selects, stalls, flushes, bubble count).
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_is_load;
   logic                  ex_branch_taken;
   logic                  mem_stall;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  stall_f;
   logic                  stall_d;
   logic                  flush_d;
   logic                  flush_e;
   logic [CNT_W-1:0]      bubble_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_is_load, ex_branch_taken, mem_stall,
      input  fwd_a_sel, fwd_b_sel, stall_f, stall_d, flush_d, flush_e, bubble_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_is_load, ex_branch_taken, mem_stall,
      output fwd_a_sel, fwd_b_sel, stall_f, stall_d, flush_d, flush_e, bubble_cnt
   );

endinterface

// File: rtl/fwd_sel_gen.sv
// Forward-select generator for one EX operand from the MEM/WB records.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: src/use_src = EX source register and read flag; mem_rec/wb_rec =
// downstream records; sel = mux3 select (MEM beats WB, x0 never forwarded).
module fwd_sel_gen
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  use_src,
   input  stage_rec_t            mem_rec,
   input  stage_rec_t            wb_rec,
   output fwd_sel_t              sel
);

   // Load flags ride along in the records but do not affect forwarding.
   logic unused_ok;
   assign unused_ok = mem_rec.is_load ^ wb_rec.is_load;

   always_comb begin
      sel = FWD_RF;
      if (use_src && (src != '0)) begin
         if (mem_rec.valid && mem_rec.reg_write && (mem_rec.rd == src)) begin
            sel = FWD_MEM;
         end else if (wb_rec.valid && wb_rec.reg_write && (wb_rec.rd == src)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, load-use bubbles, branch flush, memory freeze.
// Latency: outputs combinational (zero cycles); shadow records update on the next clk edge.
// Backpressure: mem_stall freezes all records and holds PC/IF-ID; flushes suppressed meanwhile.
// Ports: clk, rst_n (async active-low); hif (slave) carries decode fields,
// branch/stall inputs and the fwd/stall/flush/bubble_cnt outputs.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hif
);

   stage_rec_t            ex_rec;
   stage_rec_t            mem_rec;
   stage_rec_t            wb_rec;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;
   logic                  ex_use_rs1;
   logic                  ex_use_rs2;
   logic [CNT_W-1:0]      bubble_q;

   logic                  load_use;
   logic                  kill_id;
   logic                  count_bubble;
   fwd_sel_t              fwd_a;
   fwd_sel_t              fwd_b;

   assign load_use = ex_rec.valid && ex_rec.is_load && (ex_rec.rd != '0) && hif.id_valid &&
                     ((hif.id_use_rs1 && (hif.id_rs1 == ex_rec.rd)) ||
                      (hif.id_use_rs2 && (hif.id_rs2 == ex_rec.rd)));

   // A branch squashes the ID instruction anyway, so it pre-empts the bubble.
   assign kill_id      = hif.ex_branch_taken || load_use;
   assign count_bubble = !hif.mem_stall && !hif.ex_branch_taken && load_use;

   // Outputs are forced low while reset is asserted, independent of the inputs.
   assign hif.stall_f    = rst_n && (hif.mem_stall || count_bubble);
   assign hif.stall_d    = rst_n && (hif.mem_stall || count_bubble);
   assign hif.flush_d    = rst_n && !hif.mem_stall && hif.ex_branch_taken;
   assign hif.flush_e    = rst_n && !hif.mem_stall && kill_id;
   assign hif.bubble_cnt = bubble_q;
   assign hif.fwd_a_sel  = fwd_a;
   assign hif.fwd_b_sel  = fwd_b;

   // Use bits are cleared for bubbles and invalid slots, so those never forward.
   fwd_sel_gen #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src     (ex_rs1),
      .use_src (ex_use_rs1),
      .mem_rec (mem_rec),
      .wb_rec  (wb_rec),
      .sel     (fwd_a)
   );

   fwd_sel_gen #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src     (ex_rs2),
      .use_src (ex_use_rs2),
      .mem_rec (mem_rec),
      .wb_rec  (wb_rec),
      .sel     (fwd_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rec     <= '0;
         mem_rec    <= '0;
         wb_rec     <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_use_rs1 <= 1'b0;
         ex_use_rs2 <= 1'b0;
      end else if (!hif.mem_stall) begin
         wb_rec  <= mem_rec;
         mem_rec <= ex_rec;
         if (kill_id) begin
            ex_rec     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_use_rs1 <= 1'b0;
            ex_use_rs2 <= 1'b0;
         end else begin
            ex_rec     <= '{valid:     hif.id_valid,
                            rd:        hif.id_rd,
                            reg_write: hif.id_reg_write,
                            is_load:   hif.id_is_load};
            ex_rs1     <= hif.id_rs1;
            ex_rs2     <= hif.id_rs2;
            ex_use_rs1 <= hif.id_valid && hif.id_use_rs1;
            ex_use_rs2 <= hif.id_valid && hif.id_use_rs2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
      end else if (count_bubble && (bubble_q != '1)) begin
         bubble_q <= bubble_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic.
// Latency: n/a (testbench).
// Backpressure: mem_stall driven randomly and in directed bursts.
module tb_hazard_ctrl;

   localparam int RW     = 5;
   localparam int CW     = 3;
   localparam int CNTMAX = (1 << CW) - 1;

   typedef struct {
      logic          v;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic          rw;
      logic          ld;
      logic          u1;
      logic          u2;
   } inst_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hif ();

   hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hif   (hif)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
   inst_t pipe[3];
   int    cnt_m;

   logic [1:0]    last_a, last_b;
   logic          last_sf, last_fd, last_fe;
   logic [CW-1:0] last_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic inst_t nop();
      inst_t i;
      i = '{v: 1'b0, rd: '0, rs1: '0, rs2: '0, rw: 1'b0, ld: 1'b0, u1: 1'b0, u2: 1'b0};
      return i;
   endfunction

   function automatic inst_t alu(input int rd, input int a, input int b);
      inst_t i;
      i = '{v: 1'b1, rd: RW'(rd), rs1: RW'(a), rs2: RW'(b), rw: 1'b1, ld: 1'b0, u1: 1'b1, u2: 1'b1};
      return i;
   endfunction

   function automatic inst_t lw(input int rd, input int base);
      inst_t i;
      i = '{v: 1'b1, rd: RW'(rd), rs1: RW'(base), rs2: '0, rw: 1'b1, ld: 1'b1, u1: 1'b1, u2: 1'b0};
      return i;
   endfunction

   // Newest matching writer downstream of EX wins; x0 and unread sources never forward.
   function automatic logic [1:0] exp_fwd(input logic [RW-1:0] src, input logic u);
      if (!pipe[0].v || !u || src == '0) return 2'b00;
      for (int s = 1; s <= 2; s++) begin
         if (pipe[s].v && pipe[s].rw && pipe[s].rd == src) return (s == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   task automatic reset_model();
      for (int s = 0; s < 3; s++) pipe[s] = nop();
      cnt_m = 0;
   endtask

   task automatic drive(input inst_t id, input logic br, input logic ms);
      hif.id_valid        = id.v;
      hif.id_rd           = id.rd;
      hif.id_rs1          = id.rs1;
      hif.id_rs2          = id.rs2;
      hif.id_use_rs1      = id.u1;
      hif.id_use_rs2      = id.u2;
      hif.id_reg_write    = id.rw;
      hif.id_is_load      = id.ld;
      hif.ex_branch_taken = br;
      hif.mem_stall       = ms;
   endtask

   // One cycle: drive just after the edge, check at the falling edge, advance the model on the edge.
   task automatic step(input inst_t id, input logic br, input logic ms);
      logic haz, e_stall, e_fd, e_fe;
      drive(id, br, ms);
      #4;
      haz = pipe[0].v && pipe[0].ld && pipe[0].rd != '0 && id.v &&
            ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
      e_stall = ms || (!br && haz);
      e_fd    = !ms && br;
      e_fe    = !ms && (br || haz);
      chk("fwd_a",   32'(hif.fwd_a_sel),  32'(exp_fwd(pipe[0].rs1, pipe[0].u1)));
      chk("fwd_b",   32'(hif.fwd_b_sel),  32'(exp_fwd(pipe[0].rs2, pipe[0].u2)));
      chk("stall_f", 32'(hif.stall_f),    32'(e_stall));
      chk("stall_d", 32'(hif.stall_d),    32'(e_stall));
      chk("flush_d", 32'(hif.flush_d),    32'(e_fd));
      chk("flush_e", 32'(hif.flush_e),    32'(e_fe));
      chk("bubble",  32'(hif.bubble_cnt), 32'(cnt_m));
      last_a   = hif.fwd_a_sel;
      last_b   = hif.fwd_b_sel;
      last_sf  = hif.stall_f;
      last_fd  = hif.flush_d;
      last_fe  = hif.flush_e;
      last_cnt = hif.bubble_cnt;
      @(posedge clk);
      if (!ms) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (br || haz) ? nop() : id;
         if (!br && haz && cnt_m < CNTMAX) cnt_m++;
      end
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fa"}, 32'(hif.fwd_a_sel),  32'd0);
      chk({tag, "_fb"}, 32'(hif.fwd_b_sel),  32'd0);
      chk({tag, "_sf"}, 32'(hif.stall_f),    32'd0);
      chk({tag, "_sd"}, 32'(hif.stall_d),    32'd0);
      chk({tag, "_fd"}, 32'(hif.flush_d),    32'd0);
      chk({tag, "_fe"}, 32'(hif.flush_e),    32'd0);
      chk({tag, "_bc"}, 32'(hif.bubble_cnt), 32'd0);
   endtask

   initial begin
      inst_t r;
      reset_model();
      drive(nop(), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Back-to-back ALU dependency, then one with a gap.
      step(alu(3, 1, 2), 1'b0, 1'b0);
      step(alu(4, 3, 5), 1'b0, 1'b0);
      step(nop(), 1'b0, 1'b0);
      chk("b2b_a_mem", 32'(last_a), 32'h2);
      chk("b2b_b_rf",  32'(last_b), 32'h0);
      step(alu(6, 1, 2), 1'b0, 1'b0);
      step(alu(9, 1, 2), 1'b0, 1'b0);
      step(alu(4, 6, 5), 1'b0, 1'b0);
      step(nop(), 1'b0, 1'b0);
      chk("gap_a_wb", 32'(last_a), 32'h1);

      // Load-use on rs2: one bubble, then WB forwarding.
      step(lw(7, 1), 1'b0, 1'b0);
      step(alu(8, 1, 7), 1'b0, 1'b0);
      chk("lu_stall", 32'(last_sf), 32'h1);
      chk("lu_flush", 32'(last_fe), 32'h1);
      step(alu(8, 1, 7), 1'b0, 1'b0);
      chk("lu_once", 32'(last_sf), 32'h0);
      step(nop(), 1'b0, 1'b0);
      chk("lu_fwd_b", 32'(last_b), 32'h1);
      chk("lu_cnt", 32'(last_cnt), 32'h1);

      // Load into x0 never stalls or forwards.
      step(lw(0, 1), 1'b0, 1'b0);
      step(alu(14, 0, 0), 1'b0, 1'b0);
      chk("x0_nostall", 32'(last_sf), 32'h0);
      step(nop(), 1'b0, 1'b0);
      chk("x0_fa", 32'(last_a), 32'h0);

      // Branch coinciding with load-use: flush only.
      step(lw(7, 1), 1'b0, 1'b0);
      step(alu(8, 1, 7), 1'b1, 1'b0);
      chk("br_fd", 32'(last_fd), 32'h1);
      chk("br_sf", 32'(last_sf), 32'h0);
      step(lw(10, 1), 1'b0, 1'b0);
      chk("br_cnt", 32'(last_cnt), 32'h1);

      // Memory stall over a load-use, then exactly one bubble.
      repeat (3) step(alu(8, 1, 10), 1'b0, 1'b1);
      chk("ms_stall", 32'(last_sf), 32'h1);
      chk("ms_nofl",  32'(last_fe), 32'h0);
      step(alu(8, 1, 10), 1'b0, 1'b0);
      chk("ms_rel_fe", 32'(last_fe), 32'h1);
      step(alu(8, 1, 10), 1'b0, 1'b0);
      chk("ms_one", 32'(last_sf), 32'h0);
      chk("ms_cnt", 32'(last_cnt), 32'h2);
      step(nop(), 1'b0, 1'b0);
      chk("ms_fwd_b", 32'(last_b), 32'h1);

      // Mid-stream reset with MEM/WB valid and stall/branch inputs active.
      step(alu(11, 1, 2), 1'b0, 1'b0);
      step(alu(12, 1, 2), 1'b0, 1'b0);
      step(alu(13, 12, 11), 1'b0, 1'b0);
      drive(lw(7, 1), 1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      reset_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(alu(1, 12, 11), 1'b0, 1'b0);
      step(nop(), 1'b0, 1'b0);
      chk("post_rst_a", 32'(last_a), 32'h0);
      chk("post_rst_b", 32'(last_b), 32'h0);

      // Drive the counter into saturation.
      for (int k = 0; k < CNTMAX + 2; k++) begin
         step(lw(5, 1), 1'b0, 1'b0);
         step(alu(6, 5, 1), 1'b0, 1'b0);
         step(alu(6, 5, 1), 1'b0, 1'b0);
      end
      step(nop(), 1'b0, 1'b0);
      chk("sat_cnt", 32'(last_cnt), 32'(CNTMAX));

      // Random traffic on a small register set to make hazards frequent.
      for (int k = 0; k < 800; k++) begin
         r.v   = ($urandom_range(0, 9) < 8);
         r.rd  = RW'($urandom_range(0, 3));
         r.rs1 = RW'($urandom_range(0, 3));
         r.rs2 = RW'($urandom_range(0, 3));
         r.rw  = 1'($urandom_range(0, 1));
         r.ld  = ($urandom_range(0, 9) < 4);
         r.u1  = 1'($urandom_range(0, 1));
         r.u2  = 1'($urandom_range(0, 1));
         step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
